// File: rtl/sample_window_buffer_if.sv
// Stream and window-port bundle for sample_window_buffer: sample handshake toward
// the capture side, window status plus random-read port toward the FFT.
interface sample_window_buffer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic                     s_valid;
   logic                     s_ready;
   logic signed [DATA_W-1:0] s_data;
   logic                     win_valid;
   logic                     win_bank;
   logic                     win_done;
   logic        [ADDR_W-1:0] rd_addr;
   logic signed [DATA_W-1:0] rd_data;

   modport master (
      output s_valid, s_data, win_done, rd_addr,
      input  s_ready, win_valid, win_bank, rd_data
   );

   modport slave (
      input  s_valid, s_data, win_done, rd_addr,
      output s_ready, win_valid, win_bank, rd_data
   );
endinterface

// File: rtl/sample_window_buffer.sv
// Ping-pong window capture: fills two RAM banks from a sample stream and presents
// each full bank to the FFT. Optional macro DROP_ON_FULL_EN: discard-and-count instead of backpressure.
module sample_window_buffer #(
   parameter int WINDOW_SIZE = 4096,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = $clog2(WINDOW_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sample_window_buffer_if.slave bus,
   output logic                  overflow,
   input  logic                  clr_overflow
`ifdef DROP_ON_FULL_EN
   ,
   output logic [15:0]           drop_count
`endif
);

   typedef enum logic {W_FILL, W_WAIT_FREE} w_state_e;
   typedef enum logic {R_IDLE, R_PRESENT}   r_state_e;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WINDOW_SIZE - 1);

   w_state_e                 w_state_q, w_state_d;
   r_state_e                 r_state_q, r_state_d;
   logic                     wr_bank_q, wr_bank_d;
   logic        [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic        [1:0]        full_q, full_d;
   logic                     win_bank_q, win_bank_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic                     overflow_q, overflow_d;
   logic signed [DATA_W-1:0] rd_data_q, rd_data_d;

   logic s_ready, release_win, other_free, wr_en, stall_evt;

   logic signed [DATA_W-1:0] mem [0:2*WINDOW_SIZE-1];

`ifdef DROP_ON_FULL_EN
   assign s_ready = 1'b1;
`else
   assign s_ready = (w_state_q == W_FILL);
`endif

   // A release in this cycle frees the bank before the writer looks at it.
   assign release_win = (r_state_q == R_PRESENT) && bus.win_done;
   assign other_free  = !full_q[~wr_bank_q] || (release_win && (win_bank_q != wr_bank_q));
   assign wr_en       = bus.s_valid && s_ready && (w_state_q == W_FILL);
   assign stall_evt   = bus.s_valid && (w_state_q == W_WAIT_FREE);

   always_comb begin
      w_state_d = w_state_q;
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      full_d    = full_q;
      if (release_win) full_d[win_bank_q] = 1'b0;
      case (w_state_q)
         W_FILL: begin
            if (wr_en) begin
               wr_idx_d = wr_idx_q + ADDR_W'(1);
               if (wr_idx_q == LAST_IDX) begin
                  full_d[wr_bank_q] = 1'b1;
                  if (other_free) wr_bank_d = ~wr_bank_q;
                  else            w_state_d = W_WAIT_FREE;
               end
            end
         end
         W_WAIT_FREE: begin
            if (other_free) begin
               wr_bank_d = ~wr_bank_q;
               w_state_d = W_FILL;
            end
         end
         default: w_state_d = W_FILL;
      endcase
   end

   // Banks fill alternately, so rd_ptr always names the oldest full bank.
   always_comb begin
      r_state_d  = r_state_q;
      win_bank_d = win_bank_q;
      rd_ptr_d   = rd_ptr_q;
      case (r_state_q)
         R_IDLE: begin
            if (full_q[rd_ptr_q]) begin
               r_state_d  = R_PRESENT;
               win_bank_d = rd_ptr_q;
            end
         end
         R_PRESENT: begin
            if (bus.win_done) begin
               r_state_d = R_IDLE;
               rd_ptr_d  = ~rd_ptr_q;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      overflow_d = stall_evt | (overflow_q & ~clr_overflow);
      rd_data_d  = mem[{win_bank_q, bus.rd_addr}];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_FILL;
         r_state_q  <= R_IDLE;
         wr_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         full_q     <= 2'b00;
         win_bank_q <= 1'b0;
         rd_ptr_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         wr_bank_q  <= wr_bank_d;
         wr_idx_q   <= wr_idx_d;
         full_q     <= full_d;
         win_bank_q <= win_bank_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank_q, wr_idx_q}] <= bus.s_data;
   end

   // Read stage: rd_addr to rd_data, one registered cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

`ifdef DROP_ON_FULL_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] drop_count_q, drop_count_d;

   always_comb begin
      if (clr_overflow)   drop_count_d = stall_evt ? 16'd1 : 16'd0;
      else if (stall_evt) drop_count_d = sat_inc16(drop_count_q);
      else                drop_count_d = drop_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_count_q <= 16'd0;
      else        drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;
`endif

   assign bus.s_ready   = s_ready;
   assign bus.win_valid = (r_state_q == R_PRESENT);
   assign bus.win_bank  = win_bank_q;
   assign bus.rd_data   = rd_data_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_sample_window_buffer.sv
// Bench for sample_window_buffer (8-sample windows): directed corner sequences,
// a read-back vector table, and random traffic against a FIFO-of-windows model.
`timescale 1ns/1ps
module tb_sample_window_buffer;
   localparam int WS = 8;
   localparam int DW = 16;
   localparam int AW = 3;
`ifdef DROP_ON_FULL_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_overflow = 1'b0;
   logic overflow;
`ifdef DROP_ON_FULL_EN
   logic [15:0] drop_count;
`endif

   sample_window_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   sample_window_buffer #(.WINDOW_SIZE(WS), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef DROP_ON_FULL_EN
      ,
      .drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0]   addr;
      logic signed [15:0] exp;
   } rd_vec_t;
   rd_vec_t tbl [8];

   // Behavioural model: FIFO of full banks in fill order, plus sample storage.
   int  m_full [$];
   int  m_wbank, m_widx, m_wb, m_drop;
   bit  m_stall, m_wv, m_ovf, m_rd_known;
   logic signed [15:0] m_mem [2][WS];
   logic signed [15:0] m_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.s_valid = 1'b0; bus.s_data = '0; bus.win_done = 1'b0; bus.rd_addr = '0;
      clr_overflow = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Leaves s_valid asserted so consecutive sends stream without gaps.
   task automatic send(input int v);
      int guard;
      guard = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = 16'(v);
      while (!bus.s_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("send_ready_timeout", 32'(bus.s_ready), 32'd1);
      tick();
   endtask

   task automatic wait_win(input string name, input int bank);
      int g;
      g = 0;
      while (!bus.win_valid && g < 40) begin
         tick();
         g++;
      end
      check({name, "_valid"}, 32'(bus.win_valid), 32'd1);
      check({name, "_bank"}, 32'(bus.win_bank), bank);
   endtask

   task automatic read_chk(input string name, input int addr, input int exp);
      bus.rd_addr = AW'(addr);
      tick();
      check(name, 32'(bus.rd_data), exp);
   endtask

   function automatic bit in_full(input int b);
      foreach (m_full[i]) if (m_full[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_full.delete();
      m_wbank = 0; m_widx = 0; m_wb = 0; m_drop = 0;
      m_stall = 1'b0; m_wv = 1'b0; m_ovf = 1'b0; m_rd_known = 1'b0;
   endtask

   task automatic model_step(input bit sv, input logic signed [15:0] sd, input bit dn,
                             input int addr, input bit cl);
      bit ovf_set, drop;
      m_rd_known = m_wv;
      m_rd = m_mem[m_wb][addr];
      if (m_wv) begin
         if (dn) begin
            void'(m_full.pop_front());
            m_wv = 1'b0;
         end
      end else if (m_full.size() > 0) begin
         m_wv = 1'b1;
         m_wb = m_full[0];
      end
      ovf_set = 1'b0;
      drop = 1'b0;
      if (m_stall) begin
         if (sv) begin
            ovf_set = 1'b1;
            drop = DROP;
         end
         if (!in_full(1 - m_wbank)) begin
            m_stall = 1'b0;
            m_wbank = 1 - m_wbank;
         end
      end else if (sv) begin
         m_mem[m_wbank][m_widx] = sd;
         m_widx++;
         if (m_widx == WS) begin
            m_widx = 0;
            m_full.push_back(m_wbank);
            if (in_full(1 - m_wbank)) m_stall = 1'b1;
            else m_wbank = 1 - m_wbank;
         end
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (cl) m_ovf = 1'b0;
      if (cl) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
   endtask

   initial begin
      int perm [8];
      perm = '{3, 0, 7, 1, 6, 2, 5, 4};
      for (int i = 0; i < 8; i++) begin
         tbl[i].addr = AW'(perm[i]);
         tbl[i].exp  = 16'(perm[i] + 1);
      end

      // Reset values, sampled while reset is held.
      bus.s_valid = 1'b0; bus.s_data = '0; bus.win_done = 1'b0; bus.rd_addr = '0;
      rst_n = 1'b0;
      tick();
      check("rst_s_ready", 32'(bus.s_ready), 32'd1);
      check("rst_win_valid", 32'(bus.win_valid), 32'd0);
      check("rst_win_bank", 32'(bus.win_bank), 32'd0);
      check("rst_rd_data", 32'(bus.rd_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      tick();

      // One window 1..8, read back in scrambled order.
      for (int v = 1; v <= 8; v++) begin
         check("s1_ready", 32'(bus.s_ready), 32'd1);
         send(v);
      end
      bus.s_valid = 1'b0;
      check("s1_not_yet_valid", 32'(bus.win_valid), 32'd0);
      tick();
      check("s1_win_valid", 32'(bus.win_valid), 32'd1);
      check("s1_win_bank", 32'(bus.win_bank), 32'd0);
      for (int i = 0; i < 8; i++) read_chk("s1_tbl_rd", int'(tbl[i].addr), int'(tbl[i].exp));

      // Both banks full: stall (or drop), then release.
      do_reset();
      for (int v = 1; v <= 16; v++) send(v);
`ifdef DROP_ON_FULL_EN
      for (int v = 17; v <= 24; v++) send(v);
      bus.s_valid = 1'b0;
      check("s2_ready_kept", 32'(bus.s_ready), 32'd1);
      check("s2_drop_count", 32'(drop_count), 32'd8);
`else
      check("s2_ready_dropped", 32'(bus.s_ready), 32'd0);
      bus.s_data = 16'd17;
      tick();
      check("s2_ovf_set", 32'(overflow), 32'd1);
      tick();
      tick();
      check("s2_held", 32'(bus.s_ready), 32'd0);
      bus.s_valid = 1'b0;
`endif
      check("s2_ovf", 32'(overflow), 32'd1);
      check("s2_w0_valid", 32'(bus.win_valid), 32'd1);
      check("s2_w0_bank", 32'(bus.win_bank), 32'd0);
      bus.win_done = 1'b1;
      tick();
      bus.win_done = 1'b0;
      check("s2_ready_after_done", 32'(bus.s_ready), 32'd1);
      check("s2_gap", 32'(bus.win_valid), 32'd0);
      tick();
      check("s2_w1_valid", 32'(bus.win_valid), 32'd1);
      check("s2_w1_bank", 32'(bus.win_bank), 32'd1);
      for (int a = 0; a < 8; a++) read_chk("s2_w1_rd", a, 9 + a);

      // Sticky overflow and its clear.
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("s5_clr_idle", 32'(overflow), 32'd0);
      for (int v = 31; v <= 38; v++) send(v);
      tick();
      check("s5_restall", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      check("s5_set_wins", 32'(overflow), 32'd1);
      bus.s_valid = 1'b0;
      tick();
      clr_overflow = 1'b0;
      check("s5_clr_no_event", 32'(overflow), 32'd0);

      // Release coincides with the last sample of the other bank.
      do_reset();
      for (int v = 1; v <= 8; v++) send(v);
      bus.s_valid = 1'b0;
      wait_win("s3_w0", 0);
      for (int v = 9; v <= 15; v++) begin
         send(v);
         check("s3_ready", 32'(bus.s_ready), 32'd1);
      end
      bus.win_done = 1'b1;
      send(16);
      bus.win_done = 1'b0;
      bus.s_valid = 1'b0;
      check("s3_ready_last", 32'(bus.s_ready), 32'd1);
      check("s3_ovf", 32'(overflow), 32'd0);
      check("s3_gap", 32'(bus.win_valid), 32'd0);
      tick();
      check("s3_w1_valid", 32'(bus.win_valid), 32'd1);
      check("s3_w1_bank", 32'(bus.win_bank), 32'd1);
      read_chk("s3_rd0", 0, 9);
      read_chk("s3_rd7", 7, 16);

      // Asynchronous reset mid-window while bank 1 is presented.
      for (int v = 101; v <= 105; v++) send(v);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("s4_win_valid", 32'(bus.win_valid), 32'd0);
      check("s4_win_bank", 32'(bus.win_bank), 32'd0);
      check("s4_s_ready", 32'(bus.s_ready), 32'd1);
      check("s4_rd_data", 32'(bus.rd_data), 32'd0);
      check("s4_ovf", 32'(overflow), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int v = 201; v <= 208; v++) send(v);
      bus.s_valid = 1'b0;
      wait_win("s4_w0", 0);
      read_chk("s4_rd0", 0, 201);
      read_chk("s4_rd4", 4, 205);
      read_chk("s4_rd7", 7, 208);

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 900; c++) begin
         bit sv, dn, cl;
         logic signed [15:0] sd;
         int a;
         sv = ($urandom_range(3) != 0);
         sd = 16'($urandom);
         dn = ($urandom_range(11) == 0);
         cl = ($urandom_range(15) == 0);
         a  = int'($urandom_range(WS - 1));
         bus.s_valid = sv; bus.s_data = sd; bus.win_done = dn;
         bus.rd_addr = AW'(a); clr_overflow = cl;
         model_step(sv, sd, dn, a, cl);
         tick();
         check("rnd_s_ready", 32'(bus.s_ready), DROP ? 32'd1 : 32'(!m_stall));
         check("rnd_win_valid", 32'(bus.win_valid), 32'(m_wv));
         check("rnd_win_bank", 32'(bus.win_bank), m_wb);
         check("rnd_overflow", 32'(overflow), 32'(m_ovf));
         if (m_rd_known) check("rnd_rd_data", 32'(bus.rd_data), 32'(m_rd));
`ifdef DROP_ON_FULL_EN
         check("rnd_drop_count", 32'(drop_count), m_drop);
`endif
      end
      bus.s_valid = 1'b0; bus.win_done = 1'b0; clr_overflow = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sample_window_buffer.md
Name: sample_window_buffer

Overview:
Producer end of the analyzer's sample window. It accepts a stream of audio samples over a valid/ready handshake and fills a ping-pong pair of RAM banks. Each full bank is presented to the FFT as a window through a random-read port. The FFT releases the bank when it finishes, so capture continues into the other bank without gaps.

Parameters:
window_size, 4096, samples per window; must be a power of two and at least 4.
value_width, 16, sample width in bits (two's complement).
addr_width, 12, equal to log2(window_size).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  asynchronous active-low reset.
s_valid  in  1  an input sample is present.
s_ready  out  1  block can accept a sample this cycle.
s_data  in  value_width  input sample.
win_valid  out  1  a complete window is readable.
win_bank  out  1  index of the bank being presented.
win_done  in  1  single-cycle pulse from the FFT: presented window is released.
rd_addr  in  addr_width  read address into the presented bank.
rd_data  out  value_width  sample at rd_addr, registered, 1-cycle latency.
overflow  out  1  sticky flag: a stall of one or more cycles has occurred.
clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: s_ready=1, win_valid=0, win_bank=0, rd_data=0, overflow=0.
- Reset internal state: wr_bank=0, wr_idx=0, both banks free.
- Asserting rst_n low mid-window discards all partial and presented data. RAM contents are don't-care after reset.
- Sample acceptance: a sample transfers when s_valid && s_ready on a rising edge.
  - The sample is written to bank[wr_bank][wr_idx].
  - wr_idx then increments and wraps from window_size-1 to 0.
- Write FSM states: FILL and WAIT_FREE.
  - FILL: s_ready=1.
    - If the transfer at wr_idx=window_size-1 occurs and the other bank is free, wr_bank toggles next cycle and the FSM stays in FILL with no bubble.
    - If the other bank is not free, go to WAIT_FREE.
  - In both cases, the completed bank is marked full.
  - WAIT_FREE: s_ready=0.
    - overflow is set on every cycle with s_valid=1, and stays set until cleared.
    - When the other bank becomes free, toggle wr_bank and return to FILL on the next cycle.
- Read FSM states: IDLE and PRESENT.
  - IDLE: when any bank is full, set win_bank to the oldest full bank and go to PRESENT. win_valid=1 from the following cycle.
  - PRESENT:
    - rd_data is registered from bank[win_bank][rd_addr] one cycle after rd_addr is applied. This holds regardless of win_valid.
    - On win_done, the bank is marked free and win_valid drops on the next cycle.
    - If the other bank is already full, PRESENT is re-entered with the toggled win_bank. win_valid is low for exactly 1 cycle between windows.
  - win_done while in IDLE is ignored.
- Simultaneous events:
  - If win_done arrives in the same cycle as the last sample of the opposite bank, the release takes effect first.
  - In that case the writer does not enter WAIT_FREE, and s_ready stays 1.
- clr_overflow in the same cycle as a new overflow event: overflow becomes 1 (set wins).
- Window order is strictly first-filled, first-presented. Sample order within a window is arrival order: address 0 holds the oldest sample.

Optional Feature:
Macro: DROP_ON_FULL_EN.
- Defined:
  - s_ready is held at 1 continuously, including during reset.
  - In WAIT_FREE, accepted samples are discarded, not written, and wr_idx does not advance.
  - overflow is set on each discarded sample.
  - An extra output drop_count (16 bits, saturating, reset 0, cleared by clr_overflow) counts discarded samples.
- Undefined: the backpressure behaviour described above, and no drop_count port.

Test Plan:
All scenarios use window_size=8, addr_width=3.
- Reset, then stream samples 1..8 with s_valid=1 continuously → s_ready stays 1; win_valid rises, win_bank=0; reading rd_addr 0..7 returns 1..8, each one cycle after its address.
- Stream 1..24 continuously with no win_done → bank 1 fills with 9..16; s_ready drops after sample 16 is accepted; overflow=1; samples 17+ are held. Pulse win_done → s_ready=1 the next cycle; win_valid low for 1 cycle, then win_bank=1 with data 9..16.
- Pulse win_done in the same cycle that sample 16 is accepted (bank 0 presented) → s_ready never drops; overflow stays 0; the next window presented is bank 1.
- Assert rst_n low after 5 samples while a window is presented → all outputs return to reset values immediately; the next 8 samples form window 0 starting at address 0.
- Set overflow, then assert clr_overflow with no new stall → overflow=0; assert clr_overflow while stalled with s_valid=1 → overflow stays 1.
- With DROP_ON_FULL_EN defined, repeat scenario 2 → s_ready=1 throughout; drop_count=8 after samples 17..24; bank 1 still holds 9..16.
